// File: rtl/pbvi_pkg.sv
// Shared definitions for the PBVI backup engine.
// Holds the default geometry, derived index widths, the word/vector types
// used for the default build, and the sweep FSM state encoding.
package pbvi_pkg;

    localparam int DEF_W = 16;
    localparam int DEF_S = 2;
    localparam int DEF_N = 16;
    localparam int DEF_O = 2;
    localparam int DEF_A = 3;
    localparam int DEF_B = 16;

    // Counter and index width; a dimension of size 1 still gets a 1-bit field.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NW = idx_w(DEF_N);
    localparam int DEF_OW = idx_w(DEF_O);
    localparam int DEF_AW = idx_w(DEF_A);
    localparam int DEF_BW = idx_w(DEF_B);

    typedef logic [DEF_W-1:0]  word_t;
    typedef word_t [DEF_S-1:0] vec_t;

    typedef enum logic [2:0] {
        IDLE,
        DOT,
        ACC,
        OUT,
        FIN
    } state_t;

endpackage

// File: rtl/pbvi_dot_lane.sv
// Combinational S-lane dot product.
// Ports:
//   alpha_vec  in   S x W  candidate alpha vector
//   belief_vec in   S x W  belief point
//   dot        out  2W+clog2(S)  exact unsigned dot product (no truncation)
module pbvi_dot_lane #(
    parameter int W = 16,
    parameter int S = 2
) (
    input  logic [S-1:0][W-1:0]        alpha_vec,
    input  logic [S-1:0][W-1:0]        belief_vec,
    output logic [2*W+$clog2(S)-1:0]   dot
);

    localparam int PW = 2 * W;
    localparam int DW = 2 * W + $clog2(S);

    logic [S-1:0][PW-1:0] prod;

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_lane
            assign prod[gi] = PW'(alpha_vec[gi]) * PW'(belief_vec[gi]);
        end
    endgenerate

    // Written as a chain; synthesis balances it into a tree.
    always_comb begin
        dot = '0;
        for (int s = 0; s < S; s++) begin
            dot = dot + DW'(prod[s]);
        end
    end

endmodule

// File: rtl/pbvi_backup_engine.sv
// Time-multiplexed point-based value-iteration backup engine.
// For every (belief b, action a) it scans all (o, n) candidates through one
// shared dot lane, keeps the argmax index per observation, then forms
// reward[a] + sum_o alpha[a][o][idx_o] and presents it on a valid/ready port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse starting a sweep (ignored when busy)
//   alpha, reward, belief operand tables, held stable while busy
//   busy, done            sweep in progress / one-cycle completion pulse
//   out_valid, out_ready  result handshake
//   out_point, out_action belief and action index of the result
//   out_vec, out_idx      backed-up vector and selected alpha per observation
module pbvi_backup_engine
    import pbvi_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int S   = DEF_S,
    parameter int N   = DEF_N,
    parameter int O   = DEF_O,
    parameter int A   = DEF_A,
    parameter int B   = DEF_B,
    parameter int SAT = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [A-1:0][O-1:0][N-1:0][S-1:0][W-1:0] alpha,
    input  logic [A-1:0][S-1:0][W-1:0]              reward,
    input  logic [B-1:0][S-1:0][W-1:0]              belief,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [idx_w(B)-1:0]                     out_point,
    output logic [idx_w(A)-1:0]                     out_action,
    output logic [S-1:0][W-1:0]                     out_vec,
    output logic [O-1:0][idx_w(N)-1:0]              out_idx
);

    localparam int NW = idx_w(N);
    localparam int OW = idx_w(O);
    localparam int AW = idx_w(A);
    localparam int BW = idx_w(B);
    localparam int DW = 2 * W + $clog2(S);
    localparam int SW = W + $clog2(O + 1);

    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [OW-1:0] O_LAST = OW'(O - 1);
    localparam logic [AW-1:0] A_LAST = AW'(A - 1);
    localparam logic [BW-1:0] B_LAST = BW'(B - 1);

    state_t state_reg, state_next;

    logic [BW-1:0]          b_reg;
    logic [AW-1:0]          a_reg;
    logic [OW-1:0]          o_reg;
    logic [NW-1:0]          n_reg;
    logic [DW-1:0]          max_reg;
    logic [NW-1:0]          best_reg;
    logic [O-1:0][NW-1:0]   idx_reg;

    logic [DW-1:0]          dot;
    logic                   wins;
    logic                   last_pair;
    logic [S-1:0][SW-1:0]   sum_wide;
    logic [S-1:0][W-1:0]    vec_next;

    pbvi_dot_lane #(.W(W), .S(S)) u_dot (
        .alpha_vec  (alpha[a_reg][o_reg][n_reg]),
        .belief_vec (belief[b_reg]),
        .dot        (dot)
    );

    // First candidate of each observation seeds the running max; after that
    // only a strictly larger dot replaces it, so ties keep the lower n.
    assign wins      = (n_reg == '0) || (dot > max_reg);
    assign last_pair = (b_reg == B_LAST) && (a_reg == A_LAST);

    // Backed-up vector from the latched winners, widened so the sum is exact
    // before wrapping or clamping.
    always_comb begin
        sum_wide = '0;
        vec_next = '0;
        for (int s = 0; s < S; s++) begin
            sum_wide[s] = SW'(reward[a_reg][s]);
            for (int o = 0; o < O; o++) begin
                sum_wide[s] = sum_wide[s] + SW'(alpha[a_reg][o][idx_reg[o]][s]);
            end
            if ((SAT != 0) && (sum_wide[s][SW-1:W] != '0)) begin
                vec_next[s] = '1;
            end else begin
                vec_next[s] = sum_wide[s][W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = DOT;
            DOT:  if ((n_reg == N_LAST) && (o_reg == O_LAST)) state_next = ACC;
            ACC:  state_next = OUT;
            OUT:  if (out_ready) state_next = last_pair ? FIN : DOT;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == FIN);
    end

    // Datapath: counters, running max and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_reg      <= '0;
            a_reg      <= '0;
            o_reg      <= '0;
            n_reg      <= '0;
            max_reg    <= '0;
            best_reg   <= '0;
            idx_reg    <= '0;
            out_valid  <= 1'b0;
            out_point  <= '0;
            out_action <= '0;
            out_vec    <= '0;
            out_idx    <= '0;
        end else begin
            case (state_reg)
                DOT: begin
                    if (wins) begin
                        max_reg  <= dot;
                        best_reg <= n_reg;
                    end
                    if (n_reg == N_LAST) begin
                        // The last candidate may itself be the winner.
                        idx_reg[o_reg] <= wins ? n_reg : best_reg;
                        n_reg          <= '0;
                        o_reg          <= (o_reg == O_LAST) ? '0 : o_reg + 1'b1;
                    end else begin
                        n_reg <= n_reg + 1'b1;
                    end
                end
                ACC: begin
                    out_vec    <= vec_next;
                    out_idx    <= idx_reg;
                    out_point  <= b_reg;
                    out_action <= a_reg;
                    out_valid  <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (a_reg == A_LAST) begin
                            a_reg <= '0;
                            b_reg <= (b_reg == B_LAST) ? '0 : b_reg + 1'b1;
                        end else begin
                            a_reg <= a_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
